// File: rtl/fb_pkg.sv
// Shared types and geometry for the framebuffer pixel writer.
package fb_pkg;

  localparam int unsigned H_RES   = 160;
  localparam int unsigned V_RES   = 120;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned OFS_W   = 15;
  localparam int unsigned ADDR_W  = OFS_W + 1;
  localparam int unsigned NPIX    = H_RES * V_RES;

  typedef struct packed {
    logic [OFS_W-1:0]   ofs;
    logic [COLOR_W-1:0] color;
  } pix_req_t;

  typedef enum logic {
    IDLE,
    CLEAR
  } fsm_state_t;

  // Linear offset within one bank; caller guarantees x/y are in range.
  function automatic logic [OFS_W-1:0] pix_offset(input logic [9:0] x, input logic [9:0] y);
    return OFS_W'(20'(y) * 20'(H_RES) + 20'(x));
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous FIFO of pixel requests; a push is accepted while full if a pop
// happens on the same edge.
module pix_fifo
  import fb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  pix_req_t                 din,
  output pix_req_t                 dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);

  pix_req_t      r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign empty     = (r_count == '0);
  assign full      = (r_count == (PW+1)'(DEPTH));
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_pop  = pop && !empty;
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fb_pixel_writer.sv
// Pixel-write consumer: buffers plots, writes them to the back bank of a
// double-buffered framebuffer, and runs back-bank clears and bank swaps.
module fb_pixel_writer
  import fb_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [COLOR_W-1:0] color,
  input  logic               plot,
  input  logic               clear_req,
  input  logic [COLOR_W-1:0] clear_color,
  input  logic               swap_req,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_we,
  output logic               front_bank,
  output logic               busy,
  output logic               clear_done,
  output logic               swap_done,
  output logic               overflow
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fsm_state_t         r_state, w_state_nxt;
  logic [OFS_W-1:0]   r_ofs_cnt, w_ofs_nxt;
  logic [ADDR_W-1:0]  r_mem_addr, w_addr_nxt;
  logic [COLOR_W-1:0] r_mem_data, w_data_nxt;
  logic               r_mem_we, w_we_nxt;
  logic               r_front_bank, w_front_nxt;
  logic               r_clear_done, w_clear_done_nxt;
  logic               r_swap_done, w_swap_done_nxt;
  logic               r_clear_pend, w_clear_pend_nxt;
  logic               r_swap_pend, w_swap_pend_nxt;
  logic [COLOR_W-1:0] r_clear_color;
  logic [COLOR_W-1:0] r_active_color, w_active_color_nxt;
  logic               r_overflow;

  logic               w_in_range;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  pix_req_t           w_din;
  pix_req_t           w_dout;

  assign w_in_range = (x < 10'(H_RES)) && (y < 10'(V_RES));
  assign w_din      = '{ofs: pix_offset(x, y), color: color};
  assign w_push     = plot && w_in_range;
  // Pop condition must match the IDLE write branch below exactly.
  assign w_pop      = (r_state == IDLE) && !r_clear_pend && !w_empty;
  assign w_drop     = w_push && w_full && !w_pop;

  pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_push),
    .pop     (w_pop),
    .din     (w_din),
    .dout    (w_dout),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_comb begin
    w_state_nxt        = r_state;
    w_ofs_nxt          = r_ofs_cnt;
    w_addr_nxt         = r_mem_addr;
    w_data_nxt         = r_mem_data;
    w_we_nxt           = 1'b0;
    w_front_nxt        = r_front_bank;
    w_clear_done_nxt   = 1'b0;
    w_swap_done_nxt    = 1'b0;
    w_clear_pend_nxt   = r_clear_pend;
    w_swap_pend_nxt    = r_swap_pend;
    w_active_color_nxt = r_active_color;

    case (r_state)
      IDLE: begin
        if (r_clear_pend) begin
          w_clear_pend_nxt   = 1'b0;
          w_ofs_nxt          = '0;
          w_active_color_nxt = r_clear_color;
          w_state_nxt        = CLEAR;
        end else if (!w_empty) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = {~r_front_bank, w_dout.ofs};
          w_data_nxt = w_dout.color;
        end else if (r_swap_pend) begin
          w_front_nxt     = ~r_front_bank;
          w_swap_done_nxt = 1'b1;
          w_swap_pend_nxt = 1'b0;
        end
      end
      CLEAR: begin
        if (r_ofs_cnt == OFS_W'(NPIX)) begin
          w_clear_done_nxt = 1'b1;
          w_state_nxt      = IDLE;
        end else begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = {~r_front_bank, r_ofs_cnt};
          w_data_nxt = r_active_color;
          w_ofs_nxt  = r_ofs_cnt + OFS_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase

    // New requests land after consumption so a same-edge request is kept.
    if (clear_req) w_clear_pend_nxt = 1'b1;
    if (swap_req)  w_swap_pend_nxt  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_ofs_cnt      <= '0;
      r_mem_addr     <= '0;
      r_mem_data     <= '0;
      r_mem_we       <= 1'b0;
      r_front_bank   <= 1'b0;
      r_clear_done   <= 1'b0;
      r_swap_done    <= 1'b0;
      r_clear_pend   <= 1'b0;
      r_swap_pend    <= 1'b0;
      r_clear_color  <= '0;
      r_active_color <= '0;
      r_overflow     <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ofs_cnt      <= w_ofs_nxt;
      r_mem_addr     <= w_addr_nxt;
      r_mem_data     <= w_data_nxt;
      r_mem_we       <= w_we_nxt;
      r_front_bank   <= w_front_nxt;
      r_clear_done   <= w_clear_done_nxt;
      r_swap_done    <= w_swap_done_nxt;
      r_clear_pend   <= w_clear_pend_nxt;
      r_swap_pend    <= w_swap_pend_nxt;
      r_active_color <= w_active_color_nxt;
      r_overflow     <= r_overflow | w_drop;
      if (clear_req) r_clear_color <= clear_color;
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign mem_we     = r_mem_we;
  assign front_bank = r_front_bank;
  assign clear_done = r_clear_done;
  assign swap_done  = r_swap_done;
  assign overflow   = r_overflow;
  assign busy       = (r_state != IDLE) || (w_count != '0) || r_clear_pend || r_swap_pend;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed self-checking bench for fb_pixel_writer.
module tb_fb_pixel_writer;

  logic        clk;
  logic        reset_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [2:0]  color;
  logic        plot;
  logic        clear_req;
  logic [2:0]  clear_color;
  logic        swap_req;
  logic [15:0] mem_addr;
  logic [2:0]  mem_data;
  logic        mem_we;
  logic        front_bank;
  logic        busy;
  logic        clear_done;
  logic        swap_done;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  fb_pixel_writer #(.FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .x           (x),
    .y           (y),
    .color       (color),
    .plot        (plot),
    .clear_req   (clear_req),
    .clear_color (clear_color),
    .swap_req    (swap_req),
    .mem_addr    (mem_addr),
    .mem_data    (mem_data),
    .mem_we      (mem_we),
    .front_bank  (front_bank),
    .busy        (busy),
    .clear_done  (clear_done),
    .swap_done   (swap_done),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if ({mem_addr, mem_data, mem_we, front_bank, busy, clear_done, swap_done, overflow} !== 25'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got addr=%h data=%b we=%b fb=%b busy=%b cd=%b sd=%b ovf=%b, expected all 0",
               mem_addr, mem_data, mem_we, front_bank, busy, clear_done, swap_done, overflow);
    end
  endtask

  task automatic test_single_plot;
    x = 10'd5; y = 10'd3; color = 3'b101; plot = 1'b1;
    tick();
    plot = 1'b0;
    n_cmp++;
    if (mem_we !== 1'b0) begin n_err++; $display("FAIL plot_latency_early: got we=%b expected 0", mem_we); end
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h81E5 || mem_data !== 3'b101) begin
      n_err++;
      $display("FAIL single_plot_write: got we=%b addr=%h data=%b expected we=1 addr=81e5 data=101", mem_we, mem_addr, mem_data);
    end
    tick();
    n_cmp++;
    if (mem_we !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL single_plot_after: got we=%b busy=%b expected 0 0", mem_we, busy);
    end
  endtask

  task automatic test_out_of_range;
    int seen;
    seen = 0;
    x = 10'd160; y = 10'd0; color = 3'b111; plot = 1'b1;
    tick();
    if (mem_we) seen++;
    x = 10'd0; y = 10'd120;
    tick();
    if (mem_we) seen++;
    plot = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_we) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL out_of_range_write: got %0d writes expected 0", seen); end
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL out_of_range_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_clear;
    int guard;
    int bad;
    logic [15:0] exp_addr;
    clear_color = 3'b010; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    guard = 0;
    while (!mem_we && guard < 10) begin tick(); guard++; end
    n_cmp++;
    if (mem_we !== 1'b1) begin n_err++; $display("FAIL clear_start: got we=%b expected 1 within 10 cycles", mem_we); end
    bad = 0;
    for (int i = 0; i < 19200; i++) begin
      exp_addr = 16'(32'h8000 + i);
      if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_data !== 3'b010 || clear_done !== 1'b0) begin
        if (bad == 0)
          $display("FAIL clear_sweep: at write %0d got we=%b addr=%h data=%b cd=%b expected we=1 addr=%h data=010 cd=0",
                   i, mem_we, mem_addr, mem_data, clear_done, exp_addr);
        bad++;
      end
      if (i == 100) begin
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL clear_busy: got %b expected 1", busy); end
      end
      tick();
    end
    n_cmp++;
    if (bad != 0) n_err++;
    n_cmp++;
    if (mem_we !== 1'b0 || clear_done !== 1'b1) begin
      n_err++;
      $display("FAIL clear_done_pulse: got we=%b cd=%b expected we=0 cd=1", mem_we, clear_done);
    end
    tick();
    n_cmp++;
    if (clear_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL clear_done_end: got cd=%b busy=%b expected 0 0", clear_done, busy);
    end
  endtask

  task automatic test_clear_overflow;
    int guard;
    logic [15:0] exp_addr;
    clear_color = 3'b111; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    guard = 0;
    while (!mem_we && guard < 10) begin tick(); guard++; end
    n_cmp++;
    if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    for (int i = 0; i < 10; i++) begin
      x = 10'(i); y = 10'd10; color = 3'(i); plot = 1'b1;
      tick();
    end
    plot = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    guard = 0;
    while (!clear_done && guard < 20000) begin tick(); guard++; end
    n_cmp++;
    if (clear_done !== 1'b1 || mem_we !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clear_done: got cd=%b we=%b expected cd=1 we=0", clear_done, mem_we);
    end
    tick();
    for (int i = 0; i < 8; i++) begin
      exp_addr = 16'(32'h8640 + i);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_data !== 3'(i)) begin
        n_err++;
        $display("FAIL drain_%0d: got we=%b addr=%h data=%b expected we=1 addr=%h data=%b",
                 i, mem_we, mem_addr, mem_data, exp_addr, 3'(i));
      end
      tick();
    end
    n_cmp++;
    if (mem_we !== 1'b0 || overflow !== 1'b1 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL drain_end: got we=%b ovf=%b busy=%b expected 0 1 0", mem_we, overflow, busy);
    end
  endtask

  task automatic test_swap;
    logic [15:0] exp_addr;
    x = 10'd1; y = 10'd0; color = 3'd1; plot = 1'b1; swap_req = 1'b1;
    tick();
    swap_req = 1'b0; x = 10'd2; color = 3'd2;
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h8001 || mem_data !== 3'd1 || swap_done !== 1'b0) begin
      n_err++;
      $display("FAIL swap_w0: got we=%b addr=%h data=%b sd=%b expected 1 8001 001 0", mem_we, mem_addr, mem_data, swap_done);
    end
    x = 10'd3; color = 3'd3;
    tick();
    plot = 1'b0;
    for (int i = 2; i <= 3; i++) begin
      exp_addr = 16'(32'h8000 + i);
      n_cmp++;
      if (mem_we !== 1'b1 || mem_addr !== exp_addr || mem_data !== 3'(i) || front_bank !== 1'b0) begin
        n_err++;
        $display("FAIL swap_w%0d: got we=%b addr=%h data=%b fb=%b expected 1 %h %b 0",
                 i - 1, mem_we, mem_addr, mem_data, front_bank, exp_addr, 3'(i));
      end
      tick();
    end
    n_cmp++;
    if (swap_done !== 1'b1 || front_bank !== 1'b1 || mem_we !== 1'b0 || clear_done !== 1'b0) begin
      n_err++;
      $display("FAIL swap_taken: got sd=%b fb=%b we=%b cd=%b expected 1 1 0 0", swap_done, front_bank, mem_we, clear_done);
    end
    x = 10'd4; y = 10'd0; color = 3'd6; plot = 1'b1;
    tick();
    plot = 1'b0;
    n_cmp++;
    if (swap_done !== 1'b0) begin n_err++; $display("FAIL swap_pulse_len: got %b expected 0", swap_done); end
    tick();
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 16'h0004 || mem_data !== 3'd6) begin
      n_err++;
      $display("FAIL post_swap_write: got we=%b addr=%h data=%b expected 1 0004 110", mem_we, mem_addr, mem_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear;
    int guard;
    int seen;
    clear_color = 3'b011; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    guard = 0;
    while (!(mem_we && mem_addr[14:0] == 15'd1000) && guard < 2000) begin tick(); guard++; end
    n_cmp++;
    if (mem_we !== 1'b1 || mem_addr !== 16'd1000 || mem_data !== 3'b011) begin
      n_err++;
      $display("FAIL midclear_reach: got we=%b addr=%h data=%b expected 1 03e8 011", mem_we, mem_addr, mem_data);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    n_cmp++;
    if (mem_we !== 1'b0 || front_bank !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || mem_addr !== 16'd0) begin
      n_err++;
      $display("FAIL midclear_reset: got we=%b fb=%b busy=%b ovf=%b addr=%h expected 0 0 0 0 0000",
               mem_we, front_bank, busy, overflow, mem_addr);
    end
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (mem_we || clear_done) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_err++; $display("FAIL midclear_quiet: got %0d active cycles expected 0", seen); end
  endtask

  initial begin
    reset_n = 1'b0; x = '0; y = '0; color = '0; plot = 1'b0;
    clear_req = 1'b0; clear_color = '0; swap_req = 1'b0;
    test_reset();
    test_single_plot();
    test_out_of_range();
    test_clear();
    test_clear_overflow();
    test_swap();
    test_reset_mid_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_pixel_writer.md
Name: fb_pixel_writer

Overview:
- Consumer end of the draw pipeline's pixel-write interface (x, y, color, plot; no backpressure).
- Accepts single-cycle plot strobes, buffers them in a small FIFO, and writes them into a double-buffered framebuffer RAM port. All writes go to the back bank.
- Also runs clear-screen sweeps of the back bank and front/back bank swaps. Scanout reads the bank indicated by front_bank.

Parameters:
- H_RES, 160, horizontal resolution in pixels.
- V_RES, 120, vertical resolution in pixels.
- COLOR_W, 3, pixel colour width.
- FIFO_DEPTH, 8, pixel request FIFO entries; power of 2.
- OFS_W, 15, offset width; must satisfy 2^OFS_W >= H_RES*V_RES.
- ADDR_W, 16, framebuffer address width; equals OFS_W+1, bank bit is MSB.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- x  in  10  pixel column from draw pipeline
- y  in  10  pixel row from draw pipeline
- color  in  COLOR_W  pixel colour
- plot  in  1  pixel write strobe; one pixel per high cycle
- clear_req  in  1  single-cycle pulse; request back-bank clear
- clear_color  in  COLOR_W  fill colour; sampled when clear_req is high
- swap_req  in  1  single-cycle pulse; request bank swap
- mem_addr  out  ADDR_W  framebuffer write address {bank, offset}
- mem_data  out  COLOR_W  framebuffer write data
- mem_we  out  1  framebuffer write enable
- front_bank  out  1  bank currently displayed
- busy  out  1  high when state != IDLE, FIFO non-empty, or any request pending
- clear_done  out  1  one-cycle pulse at end of clear
- swap_done  out  1  one-cycle pulse when swap is taken
- overflow  out  1  sticky; set when a plot is dropped because the FIFO is full

Behaviour:
- Reset (synchronous, reset_n=0 at posedge clk):
  - Outputs: mem_addr=0, mem_data=0, mem_we=0, front_bank=0, busy=0, clear_done=0, swap_done=0, overflow=0.
  - FIFO emptied; pending flags cleared; state=IDLE.
  - Reset mid-clear aborts the sweep immediately; no further writes.
- Ingress:
  - Every edge with plot=1 is evaluated.
  - If x>=H_RES or y>=V_RES, the pixel is silently dropped (no overflow).
  - Otherwise, push {offset = y*H_RES + x (OFS_W bits), color}. The multiply is done at push time.
  - Push is accepted if count<FIFO_DEPTH, or if the FIFO is full and a pop occurs on the same edge. Else drop and set overflow.
- Request latching:
  - clear_req sets clear_pend and latches clear_color into a register.
  - swap_req sets swap_pend.
  - A repeat request while pending is absorbed (single pending).
- FSM states: IDLE, CLEAR.
- IDLE priority, evaluated each edge:
  1. clear_pend: clear clear_pend, ofs_cnt=0, go to CLEAR. No write this cycle.
  2. FIFO non-empty: pop one entry and register mem_we=1, mem_addr={~front_bank, offset}, mem_data=color.
  3. swap_pend, with FIFO empty and clear_pend=0: toggle front_bank, swap_done=1 for one cycle, clear swap_pend.
  4. Else mem_we=0.
- CLEAR:
  - Each edge registers mem_we=1, mem_addr={~front_bank, ofs_cnt}, mem_data=latched clear colour, then ofs_cnt++.
  - After the write of ofs_cnt=H_RES*V_RES-1, the next edge sets mem_we=0, clear_done=1 for one cycle, and returns to IDLE.
  - No FIFO pops during CLEAR; plots keep pushing until full.
  - clear_req during CLEAR sets clear_pend, so a second sweep follows.
- Latency:
  - plot sampled at edge E0 while IDLE with FIFO empty -> mem_we high after E1.
  - Sustained throughput is 1 pixel/cycle.
- Swap ordering: a swap never overtakes pixels already in the FIFO or a pending clear.
- Outputs are registered; clear_done and swap_done are never high simultaneously.

Decomposition:
- fb_pkg:
  - H_RES, V_RES, COLOR_W, OFS_W, ADDR_W localparams.
  - pix_req_t packed struct {logic [OFS_W-1:0] ofs; logic [COLOR_W-1:0] color;}.
  - fsm_state_t enum {IDLE, CLEAR}.
- Sub-module pix_fifo: synchronous FIFO of pix_req_t.
  - Parameter: DEPTH.
  - Ports: push, pop, din, dout, full, empty, count.
  - Supports push and pop on the same edge when full.

Test Plan:
- Reset, then plot x=5 y=3 color=3'b101 -> one cycle later mem_we=1, mem_addr=16'h81E5 (bank 1, offset 485), mem_data=3'b101; then mem_we=0.
- plot x=160 y=0, then x=0 y=120 -> no mem_we, overflow stays 0.
- clear_req with clear_color=3'b010 -> exactly 19200 consecutive writes at 0x8000..0xCAFF with data 3'b010 -> clear_done high for one cycle on the following edge.
- During CLEAR, 10 back-to-back valid plots -> 8 buffered, 2 dropped, overflow=1 (sticky). After clear_done, 8 consecutive writes in push order.
- 3 plots then swap_req on the same cycle as the first plot -> 3 writes with addr MSB=1, then front_bank=0->1 and swap_done pulse. The next plot is written with addr MSB=0.
- reset_n=0 for one edge mid-clear (ofs_cnt≈1000) -> next cycle mem_we=0, front_bank=0, busy=0, no further clear writes, no clear_done.
